// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_decode_pkg
//  Description : Shared RV decode definitions: base opcodes, format codes and
//                the layout of the registered decoded bundle.
//                The ID_ILLEGAL_CHK_EN macro adds the illegal flag to the bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

`ifdef ID_ILLEGAL_CHK_EN
    // Only two funct7 values are defined for base R-type ops
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
`endif

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    // Width-independent part of the decoded bundle; imm and pc travel beside it
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        fmt_e       fmt;
        logic       rs1_used;
        logic       rs2_used;
        logic       rd_wen;
`ifdef ID_ILLEGAL_CHK_EN
        logic       illegal;
`endif
    } dec_fields_t;

endpackage
`default_nettype wire

// File: rtl/rv_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rv_imm_gen
//  Description : Combinational format classifier and immediate generator.
//                Immediate is built as 32 bits then sign-extended to XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);

    logic [31:0] w_imm32;

    // Classify by opcode and assemble the format's immediate field
    always_comb begin
        w_imm32 = 32'h0;
        fmt     = FMT_NONE;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_IMM32: begin
                fmt     = FMT_I;
                w_imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                fmt     = FMT_S;
                w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                fmt     = FMT_B;
                w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt     = FMT_U;
                w_imm32 = {inst[31:12], 12'h000};
            end
            OP_JAL: begin
                fmt     = FMT_J;
                w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_OP, OP_OP32: begin
                fmt     = FMT_R;
            end
            default: begin
                fmt     = FMT_NONE;
            end
        endcase
        // Every format's sign bit is inst[31], which is also w_imm32[31] (or imm is 0)
        imm       = {XLEN{w_imm32[31]}};
        imm[31:0] = w_imm32;
    end

endmodule
`default_nettype wire

// File: rtl/id_stage_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_decoder
//  Description : Registered RV decode stage with a two-entry skid buffer,
//                valid/ready on both sides and synchronous flush.
//                Define ID_ILLEGAL_CHK_EN to add the out_illegal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage_decoder
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
`ifdef ID_ILLEGAL_CHK_EN
    output logic            out_illegal,
`endif
    output logic            out_rd_wen
);

    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    dec_fields_t     w_dec;
    logic            w_accept;
    logic            w_main_free;

    logic            r_main_valid;
    dec_fields_t     r_main_dec;
    logic [XLEN-1:0] r_main_imm;
    logic [PC_W-1:0] r_main_pc;

    logic            r_skid_valid;
    dec_fields_t     r_skid_dec;
    logic [XLEN-1:0] r_skid_imm;
    logic [PC_W-1:0] r_skid_pc;

    rv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst (in_inst),
        .imm  (w_imm),
        .fmt  (w_fmt)
    );

    // Decode the incoming instruction into bundle fields and use flags
    always_comb begin
        w_dec          = '0;
        w_dec.opcode   = in_inst[6:0];
        w_dec.funct3   = in_inst[14:12];
        w_dec.funct7   = in_inst[31:25];
        w_dec.rs1      = in_inst[19:15];
        w_dec.rs2      = in_inst[24:20];
        w_dec.rd       = in_inst[11:7];
        w_dec.fmt      = w_fmt;
        w_dec.rs1_used = (w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                         (w_fmt == FMT_S) || (w_fmt == FMT_B);
        w_dec.rs2_used = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
        // Writes to x0 are architecturally discarded, so never request them
        w_dec.rd_wen   = ((w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                          (w_fmt == FMT_U) || (w_fmt == FMT_J)) &&
                         (in_inst[11:7] != 5'd0);
`ifdef ID_ILLEGAL_CHK_EN
        w_dec.illegal  = (in_inst[1:0] != 2'b11) || (w_fmt == FMT_NONE) ||
                         ((w_fmt == FMT_R) &&
                          (in_inst[31:25] != FUNCT7_BASE) &&
                          (in_inst[31:25] != FUNCT7_ALT));
        if (w_dec.illegal) begin
            w_dec.rd_wen = 1'b0;
        end
`endif
    end

    // in_ready is the registered complement of skid occupancy; flush blocks accept
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_main_free = !r_main_valid || out_ready;

    // Two-entry buffer: main feeds the output, skid catches one beat of backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_dec   <= '0;
            r_main_imm   <= '0;
            r_main_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_dec   <= '0;
            r_skid_imm   <= '0;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                // in_ready is low here, so no new beat competes with the skid entry
                r_main_valid <= 1'b1;
                r_main_dec   <= r_skid_dec;
                r_main_imm   <= r_skid_imm;
                r_main_pc    <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_dec   <= w_dec;
                r_main_imm   <= w_imm;
                r_main_pc    <= in_pc;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_dec   <= w_dec;
            r_skid_imm   <= w_imm;
            r_skid_pc    <= in_pc;
        end
    end

    assign in_ready     = !r_skid_valid;
    assign out_valid    = r_main_valid;
    assign out_pc       = r_main_pc;
    assign out_opcode   = r_main_dec.opcode;
    assign out_funct3   = r_main_dec.funct3;
    assign out_funct7   = r_main_dec.funct7;
    assign out_rs1      = r_main_dec.rs1;
    assign out_rs2      = r_main_dec.rs2;
    assign out_rd       = r_main_dec.rd;
    assign out_imm      = r_main_imm;
    assign out_fmt      = r_main_dec.fmt;
    assign out_rs1_used = r_main_dec.rs1_used;
    assign out_rs2_used = r_main_dec.rs2_used;
    assign out_rd_wen   = r_main_dec.rd_wen;
`ifdef ID_ILLEGAL_CHK_EN
    assign out_illegal  = r_main_dec.illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_stage_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage_decoder
//  Description : Self-checking bench for id_stage_decoder: directed decode
//                table, handshake corner sequences and randomized traffic
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_decoder;
    import rv_decode_pkg::*;

    localparam int XLEN = 64;
    localparam int PC_W = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_rd_wen;
`ifdef ID_ILLEGAL_CHK_EN
    logic            out_illegal;
`endif

    id_stage_decoder #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7   (out_funct7),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_imm      (out_imm),
        .out_fmt      (out_fmt),
        .out_rs1_used (out_rs1_used),
        .out_rs2_used (out_rs2_used),
`ifdef ID_ILLEGAL_CHK_EN
        .out_illegal  (out_illegal),
`endif
        .out_rd_wen   (out_rd_wen)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } item_t;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        rs1u;
        logic        rs2u;
        logic        wen;
        logic        ill;
    } ref_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        rs1u;
        logic        rs2u;
        logic        wen;
    } vec_t;

    item_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the format table, using signed arithmetic
    function automatic ref_t ref_decode(input logic [31:0] i);
        ref_t   r;
        longint v;
        r = '0;
        v = 0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h1B: begin
                r.fmt = FMT_I; v = longint'($signed(i[31:20]));
                r.rs1u = 1'b1; r.wen = 1'b1;
            end
            7'h23: begin
                r.fmt = FMT_S; v = longint'($signed({i[31:25], i[11:7]}));
                r.rs1u = 1'b1; r.rs2u = 1'b1;
            end
            7'h63: begin
                r.fmt = FMT_B; v = 2 * longint'($signed({i[31], i[7], i[30:25], i[11:8]}));
                r.rs1u = 1'b1; r.rs2u = 1'b1;
            end
            7'h37, 7'h17: begin
                r.fmt = FMT_U; v = 4096 * longint'($signed(i[31:12]));
                r.wen = 1'b1;
            end
            7'h6F: begin
                r.fmt = FMT_J; v = 2 * longint'($signed({i[31], i[19:12], i[20], i[30:21]}));
                r.wen = 1'b1;
            end
            7'h33, 7'h3B: begin
                r.fmt = FMT_R; r.rs1u = 1'b1; r.rs2u = 1'b1; r.wen = 1'b1;
            end
            default: r.fmt = FMT_NONE;
        endcase
        r.imm = v;
        if (i[11:7] == 5'd0) r.wen = 1'b0;
`ifdef ID_ILLEGAL_CHK_EN
        r.ill = (i[1:0] != 2'b11) || (r.fmt == FMT_NONE) ||
                ((r.fmt == FMT_R) && (i[31:25] != 7'h00) && (i[31:25] != 7'h20));
        if (r.ill) r.wen = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk_out(input item_t it);
        ref_t r;
        r = ref_decode(it.inst);
        chk("pc",       out_pc,       it.pc);
        chk("opcode",   out_opcode,   it.inst[6:0]);
        chk("funct3",   out_funct3,   it.inst[14:12]);
        chk("funct7",   out_funct7,   it.inst[31:25]);
        chk("rs1",      out_rs1,      it.inst[19:15]);
        chk("rs2",      out_rs2,      it.inst[24:20]);
        chk("rd",       out_rd,       it.inst[11:7]);
        chk("imm",      out_imm,      r.imm);
        chk("fmt",      out_fmt,      r.fmt);
        chk("rs1_used", out_rs1_used, r.rs1u);
        chk("rs2_used", out_rs2_used, r.rs2u);
        chk("rd_wen",   out_rd_wen,   r.wen);
`ifdef ID_ILLEGAL_CHK_EN
        chk("illegal",  out_illegal,  r.ill);
`endif
    endtask

    task automatic check_state();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready",  in_ready,  q.size() < 2);
        if (q.size() > 0) chk_out(q[0]);
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at next negedge
    task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic rdy, input logic fl);
        bit exp_ready;
        exp_ready = (q.size() < 2);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (v && exp_ready) q.push_back('{inst, pc});
        end
        @(negedge clk);
        check_state();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [12];
        logic [31:0] x;
        ops = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17,
                7'h6F, 7'h67, 7'h33, 7'h1B, 7'h3B, 7'h0B};
        x = $urandom;
        if ($urandom_range(0, 3) != 0) x[6:0] = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 3) == 0) x[11:7] = 5'd0;
        if ($urandom_range(0, 3) == 0) x[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return x;
    endfunction

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'hFFF00093, FMT_I, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'hFE000EE3, FMT_B, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h123452B7, FMT_U, 64'h0000_0000_1234_5000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'h001000EF, FMT_J, 64'h0000_0000_0000_0800, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h00000013, FMT_I, 64'h0,                   1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h002081B3, FMT_R, 64'h0,                   1'b1, 1'b1, 1'b1};
        vecs[6] = '{32'h0020A423, FMT_S, 64'h8,                   1'b1, 1'b1, 1'b0};
        vecs[7] = '{32'hFE20AE23, FMT_S, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h80000097, FMT_U, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{32'h00000000, FMT_NONE, 64'h0,                1'b0, 1'b0, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst in_ready",  in_ready,  1'b1);
        chk("rst out_pc",    out_pc,    64'h0);
        chk("rst out_imm",   out_imm,   64'h0);
        chk("rst out_fmt",   out_fmt,   3'd0);
        @(negedge clk);

        // Directed decode table, streamed back-to-back with downstream always ready
        for (int k = 0; k < 10; k++) begin
            step(1'b1, vecs[k].inst, 64'(k * 4), 1'b1, 1'b0);
            chk("tbl valid", out_valid,    1'b1);
            chk("tbl fmt",   out_fmt,      vecs[k].fmt);
            chk("tbl imm",   out_imm,      vecs[k].imm);
            chk("tbl rs1u",  out_rs1_used, vecs[k].rs1u);
            chk("tbl rs2u",  out_rs2_used, vecs[k].rs2u);
            chk("tbl wen",   out_rd_wen,   vecs[k].wen);
`ifdef ID_ILLEGAL_CHK_EN
            chk("tbl illegal", out_illegal, vecs[k].inst == 32'h0);
`endif
        end
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Three back-to-back beats against a stalled output: only two accepted
        step(1'b1, 32'h00100093, 64'h100, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 64'h104, 1'b0, 1'b0);
        step(1'b1, 32'h00300193, 64'h108, 1'b0, 1'b0);
        chk("bp in_ready", in_ready, 1'b0);
        chk("bp head pc",  out_pc,   64'h100);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("bp 2nd pc",   out_pc,   64'h104);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("bp drained",  out_valid, 1'b0);

        // Flush with both entries full; the beat offered in the flush cycle is dropped
        step(1'b1, 32'h00400213, 64'h200, 1'b0, 1'b0);
        step(1'b1, 32'h00500293, 64'h204, 1'b0, 1'b0);
        step(1'b1, 32'h00600313, 64'h208, 1'b0, 1'b1);
        chk("flush out_valid", out_valid, 1'b0);
        chk("flush in_ready",  in_ready,  1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream with both entries full
        step(1'b1, 32'h00700393, 64'h300, 1'b0, 1'b0);
        step(1'b1, 32'h00800413, 64'h304, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst out_valid", out_valid, 1'b0);
        chk("arst in_ready",  in_ready,  1'b1);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Randomized traffic with backpressure and occasional flush
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
